// File: rtl/arbitro_qos_if.sv
// FIFO-bank side of the QoS arbiter: empty flags and downstream back-pressure
// in, one-hot pop and the selected queue index out.
interface arbitro_qos_if #(
   parameter int QUEUE_QUANTITY = 4
);
   localparam int QW = $clog2(QUEUE_QUANTITY);

   logic [QUEUE_QUANTITY-1:0] fifo_empty;
   logic                      down_full;
   logic [QUEUE_QUANTITY-1:0] pop;
   logic [QW-1:0]             sel;
   logic                      valid;

   modport master (
      output fifo_empty, down_full,
      input  pop, sel, valid
   );

   modport slave (
      input  fifo_empty, down_full,
      output pop, sel, valid
   );
endinterface

// File: rtl/arbitro_qos.sv
// QoS pop arbiter: round-robin, weighted round-robin and table-driven modes.
// Optional ARBITRO_PRIO0_EN gives queue 0 strict priority over every mode.
module arbitro_qos #(
   parameter int QUEUE_QUANTITY    = 4,
   parameter int MAX_WEIGHT        = 64,
   parameter int TABLE_SIZE        = 8,
   parameter int TIPOS_ROUND_ROBIN = 3,
   localparam int WW = $clog2(MAX_WEIGHT),
   localparam int MW = $clog2(TIPOS_ROUND_ROBIN),
   localparam int QW = $clog2(QUEUE_QUANTITY),
   localparam int TW = $clog2(TABLE_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enb,
   input  logic                         iniciar,
   input  logic [MW-1:0]                seleccion_roundRobin,
   input  logic [QUEUE_QUANTITY*WW-1:0] pesos,
   input  logic [TABLE_SIZE*WW-1:0]     pesosArbitraje,
   input  logic [TABLE_SIZE*QW-1:0]     selecciones,
   arbitro_qos_if.slave                 bus
);

   localparam logic [MW-1:0] MODE_WRR   = MW'(1);
   localparam logic [MW-1:0] MODE_TABLE = MW'(2);

   logic [QW-1:0] ptr, ptr_n;
   logic [TW-1:0] tidx, tidx_n;
   logic [WW-1:0] cnt, cnt_n;

   logic [QUEUE_QUANTITY-1:0] empty;
   logic                      found;
   logic [QW-1:0]             g, idx;
   logic [WW-1:0]             c, w;
   logic [TW-1:0]             te, tj;
   logic                      reached;

   assign empty = bus.fifo_empty;

   // NOTE: every variable gets a default at the top so no path through the
   // case/loop structure can leave one unassigned and infer a latch.
   always_comb begin
      found   = 1'b0;
      g       = '0;
      idx     = '0;
      c       = '0;
      w       = '0;
      te      = tidx;
      tj      = '0;
      reached = 1'b0;
      ptr_n   = ptr;
      tidx_n  = tidx;
      cnt_n   = cnt;

      if (rst && enb && iniciar) begin
         ptr_n  = '0;
         tidx_n = '0;
         cnt_n  = '0;
      end else if (rst && enb && !bus.down_full) begin
`ifdef ARBITRO_PRIO0_EN
         if (!empty[0]) begin
            found = 1'b1;
            g     = '0;
         end else
`endif
         case (seleccion_roundRobin)
            MODE_WRR: begin
               // Current queue keeps its burst count; a skip restarts it at zero.
               if (pesos[ptr*WW +: WW] != '0 && !empty[ptr]) begin
                  found = 1'b1;
                  g     = ptr;
                  c     = cnt;
               end else begin
                  for (int k = 1; k < QUEUE_QUANTITY; k++) begin
                     idx = ptr + QW'(k);
                     if (!found && pesos[idx*WW +: WW] != '0 && !empty[idx]) begin
                        found = 1'b1;
                        g     = idx;
                     end
                  end
               end
               if (found) begin
                  w       = pesos[g*WW +: WW];
                  reached = ({1'b0, c} + (WW+1)'(1)) >= {1'b0, w};
                  ptr_n   = reached ? g + QW'(1) : g;
                  cnt_n   = reached ? '0 : c + WW'(1);
               end
            end
            MODE_TABLE: begin
               if (pesosArbitraje[tidx*WW +: WW] != '0 && !empty[selecciones[tidx*QW +: QW]]) begin
                  found = 1'b1;
                  c     = cnt;
               end else begin
                  for (int k = 1; k < TABLE_SIZE; k++) begin
                     tj = tidx + TW'(k);
                     if (!found && pesosArbitraje[tj*WW +: WW] != '0 &&
                         !empty[selecciones[tj*QW +: QW]]) begin
                        found = 1'b1;
                        te    = tj;
                     end
                  end
               end
               if (found) begin
                  g       = selecciones[te*QW +: QW];
                  w       = pesosArbitraje[te*WW +: WW];
                  reached = ({1'b0, c} + (WW+1)'(1)) >= {1'b0, w};
                  tidx_n  = reached ? te + TW'(1) : te;
                  cnt_n   = reached ? '0 : c + WW'(1);
               end
            end
            default: begin
               // Plain round-robin; the unused mode encoding lands here too.
               for (int k = 0; k < QUEUE_QUANTITY; k++) begin
                  idx = ptr + QW'(k);
                  if (!found && !empty[idx]) begin
                     found = 1'b1;
                     g     = idx;
                  end
               end
               if (found) ptr_n = g + QW'(1);
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr  <= '0;
         tidx <= '0;
         cnt  <= '0;
      end else begin
         ptr  <= ptr_n;
         tidx <= tidx_n;
         cnt  <= cnt_n;
      end
   end

   assign bus.pop   = found ? (QUEUE_QUANTITY'(1) << g) : '0;
   assign bus.sel   = found ? g : '0;
   assign bus.valid = found;

endmodule

// File: tb/tb_arbitro_qos.sv
// Directed-vector bench for arbitro_qos; build with +define+ARBITRO_PRIO0_EN
// to exercise the strict-priority variant instead of the arbitration modes.
module tb_arbitro_qos;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic        iniciar;
   logic [1:0]  modo;
   logic [23:0] pesos;
   logic [47:0] pesos_arb;
   logic [15:0] selecciones;

   int checks = 0;
   int errors = 0;

   arbitro_qos_if #(.QUEUE_QUANTITY(4)) bus ();

   arbitro_qos dut (
      .clk                  (clk),
      .rst                  (rst),
      .enb                  (enb),
      .iniciar              (iniciar),
      .seleccion_roundRobin (modo),
      .pesos                (pesos),
      .pesosArbitraje       (pesos_arb),
      .selecciones          (selecciones),
      .bus                  (bus)
   );

   always #5 clk = ~clk;

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      advance();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      bus.fifo_empty = 4'b0000;
      rst = 1'b0;
      advance();
      sample();
      checks++;
      if (bus.pop !== 4'b0000 || bus.valid !== 1'b0 || bus.sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_outputs: pop=%b valid=%b sel=%0d required pop=0000 valid=0 sel=0",
                  bus.pop, bus.valid, bus.sel);
      end
      advance();
      rst = 1'b1;
      sample();
      checks++;
      if (bus.pop !== 4'b0001 || bus.valid !== 1'b1 || bus.sel !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_grant: pop=%b valid=%b sel=%0d required pop=0001 valid=1 sel=0",
                  bus.pop, bus.valid, bus.sel);
      end
      advance();
   endtask

   task automatic test_rr();
      int exp_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      modo = 2'd0;
      bus.fifo_empty = 4'b0000;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sample();
         checks++;
         if (bus.sel !== 2'(exp_seq[i]) || bus.pop !== 4'(1 << exp_seq[i]) || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL rr[%0d]: sel=%0d pop=%b valid=%b required sel=%0d", i,
                     bus.sel, bus.pop, bus.valid, exp_seq[i]);
         end
         advance();
      end
      // Unused mode encoding behaves as RR; q1 empty is skipped.
      modo = 2'd3;
      bus.fifo_empty = 4'b0010;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++;
         if (bus.sel !== 2'(i == 0 ? 0 : i + 1) || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_mode3[%0d]: sel=%0d valid=%b required sel=%0d", i,
                     bus.sel, bus.valid, (i == 0 ? 0 : i + 1));
         end
         advance();
      end
   endtask

   task automatic test_wrr();
      int exp_seq[9] = '{0, 0, 0, 1, 1, 3, 0, 0, 0};
      modo = 2'd1;
      pesos = {6'd1, 6'd0, 6'd2, 6'd3};
      bus.fifo_empty = 4'b0000;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         sample();
         checks++;
         if (bus.sel !== 2'(exp_seq[i]) || bus.pop !== 4'(1 << exp_seq[i]) || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL wrr[%0d]: sel=%0d pop=%b valid=%b required sel=%0d", i,
                     bus.sel, bus.pop, bus.valid, exp_seq[i]);
         end
         advance();
      end
   endtask

   task automatic test_wrr_max_weight();
      int q0_pops = 0;
      modo = 2'd1;
      pesos = {6'd0, 6'd0, 6'd1, 6'd63};
      bus.fifo_empty = 4'b0000;
      do_reset();
      for (int i = 0; i < 63; i++) begin
         sample();
         if (bus.sel === 2'd0 && bus.valid === 1'b1) q0_pops++;
         advance();
      end
      checks++;
      if (q0_pops !== 63) begin
         errors++;
         $display("FAIL wrr_w63_burst: q0 pops=%0d required 63", q0_pops);
      end
      sample();
      checks++;
      if (bus.sel !== 2'd1 || bus.valid !== 1'b1) begin
         errors++;
         $display("FAIL wrr_w63_next: sel=%0d valid=%b required sel=1 valid=1", bus.sel, bus.valid);
      end
      advance();
   endtask

   task automatic test_table();
      int exp_seq[6] = '{2, 2, 0, 2, 2, 0};
      modo = 2'd2;
      pesos_arb = '0;
      pesos_arb[5:0]   = 6'd2;
      pesos_arb[11:6]  = 6'd0;
      pesos_arb[17:12] = 6'd1;
      selecciones = '0;
      selecciones[1:0] = 2'd2;
      selecciones[3:2] = 2'd1;
      selecciones[5:4] = 2'd0;
      bus.fifo_empty = 4'b0000;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         sample();
         checks++;
         if (bus.sel !== 2'(exp_seq[i]) || bus.pop !== 4'(1 << exp_seq[i]) || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL table[%0d]: sel=%0d pop=%b valid=%b required sel=%0d", i,
                     bus.sel, bus.pop, bus.valid, exp_seq[i]);
         end
         advance();
      end
   endtask

   task automatic test_stall();
      modo = 2'd0;
      bus.fifo_empty = 4'b1111;
      do_reset();
      sample();
      checks++;
      if (bus.pop !== 4'b0000 || bus.valid !== 1'b0 || bus.sel !== 2'd0) begin
         errors++;
         $display("FAIL all_empty: pop=%b valid=%b sel=%0d required pop=0000", bus.pop, bus.valid, bus.sel);
      end
      advance();
      bus.fifo_empty = 4'b0000;
      sample();
      checks++;
      if (bus.sel !== 2'd0 || bus.valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_pre: sel=%0d valid=%b required sel=0", bus.sel, bus.valid);
      end
      advance();
      bus.down_full = 1'b1;
      for (int i = 0; i < 2; i++) begin
         sample();
         checks++;
         if (bus.pop !== 4'b0000 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL down_full[%0d]: pop=%b valid=%b required pop=0000", i, bus.pop, bus.valid);
         end
         advance();
      end
      bus.down_full = 1'b0;
      enb = 1'b0;
      sample();
      checks++;
      if (bus.pop !== 4'b0000 || bus.valid !== 1'b0) begin
         errors++;
         $display("FAIL enb_low: pop=%b valid=%b required pop=0000", bus.pop, bus.valid);
      end
      advance();
      enb = 1'b1;
      sample();
      checks++;
      if (bus.sel !== 2'd1 || bus.pop !== 4'b0010) begin
         errors++;
         $display("FAIL ptr_held: sel=%0d pop=%b required sel=1 pop=0010", bus.sel, bus.pop);
      end
      advance();
   endtask

   task automatic test_restart();
      int exp_seq[4] = '{0, 0, 0, 1};
      modo = 2'd1;
      pesos = {6'd1, 6'd0, 6'd2, 6'd3};
      bus.fifo_empty = 4'b0000;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         advance();   // one q0 pop, burst count now 1
         if (pass == 0) iniciar = 1'b1;
         else           rst = 1'b0;
         sample();
         checks++;
         if (bus.pop !== 4'b0000 || bus.valid !== 1'b0 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL restart%0d_gap: pop=%b valid=%b sel=%0d required pop=0000", pass,
                     bus.pop, bus.valid, bus.sel);
         end
         advance();
         iniciar = 1'b0;
         rst = 1'b1;
         for (int i = 0; i < 4; i++) begin
            sample();
            checks++;
            if (bus.sel !== 2'(exp_seq[i]) || bus.valid !== 1'b1) begin
               errors++;
               $display("FAIL restart%0d[%0d]: sel=%0d valid=%b required sel=%0d", pass, i,
                        bus.sel, bus.valid, exp_seq[i]);
            end
            advance();
         end
      end
   endtask

   task automatic test_prio0();
      modo = 2'd0;
      bus.fifo_empty = 4'b1010;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) bus.fifo_empty = 4'b1011;
         sample();
         checks++;
         if (bus.sel !== (i == 3 ? 2'd2 : 2'd0) || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL prio0[%0d]: sel=%0d valid=%b required sel=%0d", i,
                     bus.sel, bus.valid, (i == 3 ? 2 : 0));
         end
         advance();
      end
   endtask

   initial begin
      rst            = 1'b0;
      enb            = 1'b1;
      iniciar        = 1'b0;
      modo           = 2'd0;
      pesos          = '0;
      pesos_arb      = '0;
      selecciones    = '0;
      bus.fifo_empty = 4'b1111;
      bus.down_full  = 1'b0;
      advance();
      test_reset();
`ifdef ARBITRO_PRIO0_EN
      test_prio0();
`else
      test_rr();
      test_wrr();
      test_wrr_max_weight();
      test_table();
      test_stall();
      test_restart();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
